// File: rtl/fifo_uart_tx_if.sv
// FIFO-side and serial-side signals of the FIFO-draining UART transmitter.
// master drives the FIFO status/data and enable; slave is the transmitter.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done_tick;

  modport master (
    output tx_en, fifo_empty, fifo_rdata,
    input  fifo_rd_en, tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_rdata,
    output fifo_rd_en, tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one FIFO word per frame and serialises it:
// start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input logic          clk,
  input logic          reset,
  fifo_uart_tx_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [TW-1:0]         tick;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pop;
  logic                  tick_last;

  // Pop is combinational so the word under the read pointer is captured in the same cycle.
  assign pop       = (state == IDLE) && bus.tx_en && !bus.fifo_empty && !reset;
  assign tick_last = (tick == TICK_LAST);
  assign shifted   = shreg >> 1;

  assign bus.fifo_rd_en   = pop;
  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg  <= bus.fifo_rdata;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
            tick   <= '0;
            state  <= START;
          end
        end
        START: begin
          if (tick_last) begin
            tick    <= '0;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
            state   <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick  <= '0;
            shreg <= shifted;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              tx_q    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shifted[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          // Registered done pulse: raise it one cycle early so it lands on the final stop cycle.
          if (tick == TICK_PRE && bit_cnt == LAST_STOP) done_q <= 1'b1;
          if (tick_last) begin
            tick <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, cycle model of the serial line,
// and a scoreboard of words queued at push time and retired at frame end.
module tb_fifo_uart_tx;
  localparam int DW    = 8;
  localparam int C     = 4;
  localparam int SB    = 1;
  localparam int FRAME = C * (1 + DW + SB);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errs = 0, checks = 0, cyc = 0, k = 0;
  int pops = 0, frames = 0, last_pop = -1, prev_pop = -1, last_done = -1;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_word, rx_word, dummy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_rdata = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  task automatic tick();
    logic rd, exp_rd, exp_tx;
    int b;
    drive_fifo();
    #1;
    rd     = bus.fifo_rd_en;
    exp_rd = (k == 0) && !reset && bus.tx_en && !bus.fifo_empty;
    check_eq("rd_en", rd, exp_rd);
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (k != 0 && exp_q.size() != 0) dummy = exp_q.pop_front();
      k = 0;
    end else if (rd) begin
      if (fifo_q.size() != 0) dummy = fifo_q.pop_front();
      cur_word = (exp_q.size() != 0) ? exp_q[0] : '0;
      rx_word  = '0;
      k        = 1;
      prev_pop = last_pop;
      last_pop = cyc - 1;
      pops++;
    end else if (k == FRAME) begin
      k = 0;
    end else if (k != 0) begin
      k++;
    end
    @(negedge clk);
    drive_fifo();
    #1;
    b = (k == 0) ? 0 : (k - 1) / C;
    if (k == 0)       exp_tx = 1'b1;
    else if (b == 0)  exp_tx = 1'b0;
    else if (b <= DW) exp_tx = cur_word[b-1];
    else              exp_tx = 1'b1;
    check_eq("tx", bus.tx, exp_tx);
    check_eq("tx_busy", bus.tx_busy, k != 0);
    check_eq("tx_done_tick", bus.tx_done_tick, k == FRAME);
    if (bus.tx_done_tick === 1'b1) last_done = cyc;
    if (k != 0 && b >= 1 && b <= DW && ((k - 1) % C) == C / 2) rx_word[b-1] = bus.tx;
    if (k == FRAME) begin
      check_eq("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("frame_word", rx_word, exp_q.pop_front());
      frames++;
    end
  endtask

  task automatic wait_pop(input int budget);
    int p0 = pops;
    for (int i = 0; i < budget && pops == p0; i++) tick();
    check_eq("pop_timeout", pops != p0, 1);
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && k != 0; i++) tick();
    check_eq("idle_timeout", k == 0, 1);
  endtask

  task automatic run_until_k(input int target, input int budget);
    for (int i = 0; i < budget && k != target; i++) tick();
    check_eq("k_timeout", k, target);
  endtask

  initial begin
    int p0, f0;
    reset      = 1'b1;
    bus.tx_en  = 1'b0;
    drive_fifo();

    // 1. reset
    repeat (3) tick();
    check_eq("rst_tx", bus.tx, 1);
    check_eq("rst_busy", bus.tx_busy, 0);
    check_eq("rst_rd", bus.fifo_rd_en, 0);
    check_eq("rst_done", bus.tx_done_tick, 0);
    reset = 1'b0;
    tick();

    // 2. single frame 0xA5
    push_word(8'hA5);
    bus.tx_en = 1'b1;
    wait_pop(5);
    run_idle(FRAME + 5);
    check_eq("done_latency", last_done - last_pop, FRAME);

    // 3. back-to-back 0x00, 0xFF
    push_word(8'h00);
    push_word(8'hFF);
    wait_pop(5);
    wait_pop(FRAME + 5);
    check_eq("pop_period", last_pop - prev_pop, FRAME + 1);
    run_idle(FRAME + 5);

    // 4. empty FIFO with tx_en high
    p0 = pops;
    repeat (100) tick();
    check_eq("empty_pops", pops, p0);

    // 5. tx_en dropped during data bit 3
    push_word(8'h3C);
    push_word(8'h81);
    wait_pop(5);
    run_until_k(1 + C * 4 + 1, FRAME);
    bus.tx_en = 1'b0;
    f0 = frames;
    run_idle(FRAME);
    check_eq("hold_frame_done", frames, f0 + 1);
    p0 = pops;
    repeat (60) tick();
    check_eq("hold_pops", pops, p0);
    bus.tx_en = 1'b1;
    wait_pop(5);
    run_idle(FRAME + 5);

    // 6. reset pulse during data bit 5
    push_word(8'h5A);
    push_word(8'h96);
    wait_pop(5);
    run_until_k(1 + C * 6 + 1, FRAME);
    reset = 1'b1;
    tick();
    check_eq("rst_mid_tx", bus.tx, 1);
    check_eq("rst_mid_busy", bus.tx_busy, 0);
    reset = 1'b0;
    f0 = frames;
    wait_pop(5);
    run_idle(FRAME + 5);
    check_eq("frames_after_rst", frames, f0 + 1);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
